ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage placed directly upstream of the ideal ALU. It captures decoded operands, destination and ALU opcode from decode. It resolves read-after-write hazards by forwarding from the EX/MEM and MEM/WB results. It drives the ALU's two operand inputs and opcode input, and supports stall (hold) and flush (bubble insertion).

---
 rtl/ex_operand_stage_pkg.sv | 35 +++
 rtl/ex_operand_stage_if.sv | 52 +++++
 rtl/ex_operand_stage_fwd_unit.sv | 36 +++
 rtl/ex_operand_stage.sv | 85 ++++++++
 tb/tb_ex_operand_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared widths, ALU opcode / forward-select encodings and the ID/EX register layout
// for the operand stage.
package ex_operand_stage_pkg;

  localparam int unsigned word_size  = 32;
  localparam int unsigned reg_addr_w = 5;

  localparam logic [2:0] ALU_PASS    = 3'd0;
  localparam logic [2:0] ALU_NOT     = 3'd1;
  localparam logic [2:0] ALU_ADD     = 3'd2;
  localparam logic [2:0] ALU_SUB     = 3'd3;
  localparam logic [2:0] ALU_OR      = 3'd4;
  localparam logic [2:0] ALU_AND     = 3'd5;
  localparam logic [2:0] ALU_SLT     = 3'd6;
  localparam logic [2:0] ALU_ILLEGAL = 3'd7;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam logic [1:0] FWD_IMM   = 2'd3;

  typedef struct packed {
    logic                  valid;
    logic [2:0]            alu_op;
    logic [reg_addr_w-1:0] rs_addr;
    logic [reg_addr_w-1:0] rt_addr;
    logic [word_size-1:0]  opa;
    logic [word_size-1:0]  opb;
    logic                  use_imm;
    logic [reg_addr_w-1:0] rd_addr;
    logic                  reg_write;
    logic                  illegal;
  } id_ex_t;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bundle of decode, producer and ALU-side signals around the operand stage.
// slave = the stage itself, master = its surroundings.
interface ex_operand_stage_if;
  import ex_operand_stage_pkg::*;

  logic                  stall;
  logic                  flush;
  logic                  id_valid;
  logic [2:0]            id_alu_op;
  logic [reg_addr_w-1:0] id_rs_addr;
  logic [reg_addr_w-1:0] id_rt_addr;
  logic [word_size-1:0]  id_rs_data;
  logic [word_size-1:0]  id_rt_data;
  logic [word_size-1:0]  id_imm;
  logic                  id_use_imm;
  logic [reg_addr_w-1:0] id_rd_addr;
  logic                  id_reg_write;
  logic                  exmem_reg_write;
  logic [reg_addr_w-1:0] exmem_rd_addr;
  logic [word_size-1:0]  exmem_result;
  logic                  memwb_reg_write;
  logic [reg_addr_w-1:0] memwb_rd_addr;
  logic [word_size-1:0]  memwb_result;
  logic [word_size-1:0]  alu_r2;
  logic [word_size-1:0]  alu_r3;
  logic [2:0]            alu_op;
  logic                  ex_valid;
  logic [reg_addr_w-1:0] ex_rd_addr;
  logic                  ex_reg_write;
  logic                  ex_illegal;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;

  modport slave (
    input  stall, flush, id_valid, id_alu_op, id_rs_addr, id_rt_addr, id_rs_data,
           id_rt_data, id_imm, id_use_imm, id_rd_addr, id_reg_write,
           exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
    output alu_r2, alu_r3, alu_op, ex_valid, ex_rd_addr, ex_reg_write, ex_illegal,
           fwd_a_sel, fwd_b_sel
  );

  modport master (
    output stall, flush, id_valid, id_alu_op, id_rs_addr, id_rt_addr, id_rs_data,
           id_rt_data, id_imm, id_use_imm, id_rd_addr, id_reg_write,
           exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
    input  alu_r2, alu_r3, alu_op, ex_valid, ex_rd_addr, ex_reg_write, ex_illegal,
           fwd_a_sel, fwd_b_sel
  );

endinterface

// File: rtl/ex_operand_stage_fwd_unit.sv
// Combinational forwarding compare-and-mux for one ALU operand.
module fwd_unit
  import ex_operand_stage_pkg::*;
(
  input  logic [reg_addr_w-1:0] src,
  input  logic [word_size-1:0]  reg_data,
  input  logic                  use_imm,
  input  logic                  exmem_reg_write,
  input  logic [reg_addr_w-1:0] exmem_rd_addr,
  input  logic [word_size-1:0]  exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [reg_addr_w-1:0] memwb_rd_addr,
  input  logic [word_size-1:0]  memwb_result,
  output logic [word_size-1:0]  data,
  output logic [1:0]            sel
);

  logic src_nz;
  assign src_nz = (src != '0);

  // Immediate holds reg_data already; EX/MEM outranks MEM/WB as the younger producer.
  always_comb begin
    data = reg_data;
    sel  = FWD_REG;
    if (use_imm) begin
      sel = FWD_IMM;
    end else if (src_nz && exmem_reg_write && (exmem_rd_addr == src)) begin
      data = exmem_result;
      sel  = FWD_EXMEM;
    end else if (src_nz && memwb_reg_write && (memwb_rd_addr == src)) begin
      data = memwb_result;
      sel  = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with stall/flush priority, illegal-opcode squash and
// EX/MEM, MEM/WB operand forwarding feeding the ALU.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
(
  input logic                clk,
  input logic                rst,
  ex_operand_stage_if.slave  bus
);

  id_ex_t               q;
  id_ex_t               d;
  logic [word_size-1:0] fwd_a_data;
  logic [word_size-1:0] fwd_b_data;
  logic                 id_is_illegal;

  fwd_unit u_fwd_a (
    .src             (q.rs_addr),
    .reg_data        (q.opa),
    .use_imm         (1'b0),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd_addr   (bus.exmem_rd_addr),
    .exmem_result    (bus.exmem_result),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd_addr   (bus.memwb_rd_addr),
    .memwb_result    (bus.memwb_result),
    .data            (fwd_a_data),
    .sel             (bus.fwd_a_sel)
  );

  fwd_unit u_fwd_b (
    .src             (q.rt_addr),
    .reg_data        (q.opb),
    .use_imm         (q.use_imm),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd_addr   (bus.exmem_rd_addr),
    .exmem_result    (bus.exmem_result),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd_addr   (bus.memwb_rd_addr),
    .memwb_result    (bus.memwb_result),
    .data            (fwd_b_data),
    .sel             (bus.fwd_b_sel)
  );

  assign id_is_illegal = (bus.id_alu_op == ALU_ILLEGAL);

  always_comb begin
    d = q;
    if (bus.flush || !(bus.stall || bus.id_valid)) begin
      d = '0;
    end else if (bus.stall) begin
      // Re-latch forwarded operands so a producer retiring during the stall is kept.
      d.opa = fwd_a_data;
      d.opb = fwd_b_data;
    end else begin
      d.valid     = 1'b1;
      d.alu_op    = id_is_illegal ? ALU_PASS : bus.id_alu_op;
      d.rs_addr   = bus.id_rs_addr;
      d.rt_addr   = bus.id_rt_addr;
      d.opa       = bus.id_rs_data;
      d.opb       = bus.id_use_imm ? bus.id_imm : bus.id_rt_data;
      d.use_imm   = bus.id_use_imm;
      d.rd_addr   = bus.id_rd_addr;
      d.reg_write = bus.id_reg_write && !id_is_illegal;
      d.illegal   = id_is_illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  assign bus.alu_r2       = fwd_a_data;
  assign bus.alu_r3       = fwd_b_data;
  assign bus.alu_op       = q.alu_op;
  assign bus.ex_valid     = q.valid;
  assign bus.ex_rd_addr   = q.rd_addr;
  assign bus.ex_reg_write = q.reg_write & q.valid;
  assign bus.ex_illegal   = q.illegal;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table plus stall, flush and reset sequences.
module tb_ex_operand_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [31:0] rsd;
    logic [4:0]  rt;
    logic [31:0] rtd;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic        x_rw;
    logic [4:0]  x_rd;
    logic [31:0] x_res;
    logic        w_rw;
    logic [4:0]  w_rd;
    logic [31:0] w_res;
    logic [31:0] e_r2;
    logic [31:0] e_r3;
    logic [2:0]  e_op;
    logic [1:0]  e_sa;
    logic [1:0]  e_sb;
    logic        e_valid;
    logic        e_rw;
    logic        e_ill;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic valid, input logic [2:0] op, input logic [4:0] rs,
                          input logic [31:0] rsd, input logic [4:0] rt, input logic [31:0] rtd,
                          input logic use_imm, input logic [31:0] imm, input logic [4:0] rd,
                          input logic rw);
    bus.id_valid = valid;  bus.id_alu_op = op;
    bus.id_rs_addr = rs;   bus.id_rs_data = rsd;
    bus.id_rt_addr = rt;   bus.id_rt_data = rtd;
    bus.id_use_imm = use_imm; bus.id_imm = imm;
    bus.id_rd_addr = rd;   bus.id_reg_write = rw;
  endtask

  task automatic drive_prod(input logic x_rw, input logic [4:0] x_rd, input logic [31:0] x_res,
                            input logic w_rw, input logic [4:0] w_rd, input logic [31:0] w_res);
    bus.exmem_reg_write = x_rw; bus.exmem_rd_addr = x_rd; bus.exmem_result = x_res;
    bus.memwb_reg_write = w_rw; bus.memwb_rd_addr = w_rd; bus.memwb_result = w_res;
  endtask

  initial begin
    vecs[0] = '{1, 2, 3, 32'h10, 4, 32'h20, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,
                32'h10, 32'h20, 2, 0, 0, 1, 1, 0, 7};
    vecs[1] = '{1, 2, 3, 32'h10, 4, 32'h20, 0, 0, 7, 1, 1, 3, 32'hAA, 1, 3, 32'hBB,
                32'hAA, 32'h20, 2, 1, 0, 1, 1, 0, 7};
    vecs[2] = '{1, 2, 3, 32'h10, 4, 32'h20, 0, 0, 7, 1, 1, 9, 32'hAA, 1, 3, 32'hBB,
                32'hBB, 32'h20, 2, 2, 0, 1, 1, 0, 7};
    vecs[3] = '{1, 4, 0, 32'h1234, 4, 32'h20, 0, 0, 7, 1, 1, 0, 32'hFF, 0, 0, 0,
                32'h1234, 32'h20, 4, 0, 0, 1, 1, 0, 7};
    vecs[4] = '{1, 2, 3, 32'h10, 4, 32'h20, 1, 32'hFFFFFFFE, 7, 1, 1, 4, 32'h99, 1, 4, 32'h88,
                32'h10, 32'hFFFFFFFE, 2, 0, 3, 1, 1, 0, 7};
    vecs[5] = '{1, 7, 3, 32'h10, 4, 32'h20, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,
                32'h10, 32'h20, 0, 0, 0, 1, 0, 1, 7};
    vecs[6] = '{0, 2, 3, 32'h10, 4, 32'h20, 0, 0, 7, 1, 1, 3, 32'hAA, 0, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{1, 3, 1, 32'h11, 6, 32'h1, 0, 0, 2, 1, 0, 6, 32'h77, 1, 6, 32'h66,
                32'h11, 32'h66, 3, 0, 2, 1, 1, 0, 2};
    vecs[8] = '{1, 6, 2, 32'h5, 2, 32'h9, 0, 0, 0, 0, 1, 2, 32'hCC, 0, 0, 0,
                32'hCC, 32'hCC, 6, 1, 1, 1, 0, 0, 0};

    bus.stall = 0;
    bus.flush = 0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_prod(0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_r2", bus.alu_r2, 0);
    chk("reset_r3", bus.alu_r3, 0);
    chk("reset_op", {29'd0, bus.alu_op}, 0);
    chk("reset_valid", {31'd0, bus.ex_valid}, 0);
    chk("reset_sel", {28'd0, bus.fwd_a_sel, bus.fwd_b_sel}, 0);
    @(negedge clk);
    rst = 0;

    // Producers stay idle across the capture edge, then present per-vector values.
    for (int i = 0; i < 9; i++) begin
      drive_id(vecs[i].valid, vecs[i].op, vecs[i].rs, vecs[i].rsd, vecs[i].rt, vecs[i].rtd,
               vecs[i].use_imm, vecs[i].imm, vecs[i].rd, vecs[i].rw);
      drive_prod(0, 0, 0, 0, 0, 0);
      tick();
      drive_prod(vecs[i].x_rw, vecs[i].x_rd, vecs[i].x_res,
                 vecs[i].w_rw, vecs[i].w_rd, vecs[i].w_res);
      #1;
      chk($sformatf("v%0d_r2", i), bus.alu_r2, vecs[i].e_r2);
      chk($sformatf("v%0d_r3", i), bus.alu_r3, vecs[i].e_r3);
      chk($sformatf("v%0d_op", i), {29'd0, bus.alu_op}, {29'd0, vecs[i].e_op});
      chk($sformatf("v%0d_sel_a", i), {30'd0, bus.fwd_a_sel}, {30'd0, vecs[i].e_sa});
      chk($sformatf("v%0d_sel_b", i), {30'd0, bus.fwd_b_sel}, {30'd0, vecs[i].e_sb});
      chk($sformatf("v%0d_valid", i), {31'd0, bus.ex_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_reg_write", i), {31'd0, bus.ex_reg_write}, {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d_illegal", i), {31'd0, bus.ex_illegal}, {31'd0, vecs[i].e_ill});
      chk($sformatf("v%0d_rd", i), {27'd0, bus.ex_rd_addr}, {27'd0, vecs[i].e_rd});
    end

    // Combinational drop of the EX/MEM match within one cycle.
    drive_id(1, 2, 3, 32'h10, 4, 32'h20, 0, 0, 7, 1);
    drive_prod(0, 0, 0, 0, 0, 0);
    tick();
    drive_prod(1, 3, 32'hAA, 1, 3, 32'hBB);
    #1;
    chk("both_match_r2", bus.alu_r2, 32'hAA);
    bus.exmem_reg_write = 0;
    #1;
    chk("drop_exmem_r2", bus.alu_r2, 32'hBB);
    chk("drop_exmem_sel", {30'd0, bus.fwd_a_sel}, 2);

    // Stall with a one-cycle MEM/WB producer for rs=5.
    drive_id(1, 2, 5, 32'h05, 4, 32'h20, 0, 0, 8, 1);
    drive_prod(0, 0, 0, 0, 0, 0);
    tick();
    drive_id(1, 3, 1, 32'h01, 1, 32'h01, 0, 0, 9, 1);
    bus.stall = 1;
    drive_prod(0, 0, 0, 1, 5, 32'h55);
    #1;
    chk("stall_live_fwd", bus.alu_r2, 32'h55);
    tick();
    drive_prod(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("stall_keep_r2", bus.alu_r2, 32'h55);
    chk("stall_keep_sel", {30'd0, bus.fwd_a_sel}, 0);
    chk("stall_hold_op", {29'd0, bus.alu_op}, 2);
    chk("stall_hold_rd", {27'd0, bus.ex_rd_addr}, 8);

    // Flush beats stall.
    bus.flush = 1;
    tick();
    bus.flush = 0;
    bus.stall = 0;
    chk("flush_valid", {31'd0, bus.ex_valid}, 0);
    chk("flush_reg_write", {31'd0, bus.ex_reg_write}, 0);
    chk("flush_op", {29'd0, bus.alu_op}, 0);

    // Asynchronous reset mid-cycle during a stall, then normal resume.
    drive_id(1, 2, 3, 32'h10, 4, 32'h20, 0, 0, 7, 1);
    tick();
    chk("pre_reset_valid", {31'd0, bus.ex_valid}, 1);
    bus.stall = 1;
    #2;
    rst = 1;
    #1;
    chk("async_reset_r2", bus.alu_r2, 0);
    chk("async_reset_r3", bus.alu_r3, 0);
    chk("async_reset_valid", {31'd0, bus.ex_valid}, 0);
    chk("async_reset_rd", {27'd0, bus.ex_rd_addr}, 0);
    chk("async_reset_op", {29'd0, bus.alu_op}, 0);
    @(negedge clk);
    rst = 0;
    bus.stall = 0;
    drive_id(1, 5, 3, 32'h10, 4, 32'h20, 0, 0, 7, 1);
    tick();
    chk("post_reset_r2", bus.alu_r2, 32'h10);
    chk("post_reset_op", {29'd0, bus.alu_op}, 5);
    chk("post_reset_reg_write", {31'd0, bus.ex_reg_write}, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
